team_08_draw_arbiter: RTL and testbench

Shares the single pixel-drawing engine among sprite requesters (dino, cactus, score; index 0 = dino). Each requester raises a level "movement/dirty" flag and holds it until it receives a one-cycle drawDone pulse. The arbiter picks one requester, starts the engine, waits for completion, and returns drawDone to the winner. A watchdog guards against a hung engine.

---
 rtl/team_08_pkg.sv | 15 +
 rtl/team_08_arb_pick.sv | 35 +++
 rtl/team_08_draw_arbiter.sv | 104 ++++++++++
 tb/tb_team_08_draw_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/team_08_pkg.sv
// team_08_pkg: shared types and sprite indices for the team 08 draw arbiter.
//   state_t     - game state (IDLE/RUN/WIN/OVER)
//   arb_state_t - arbiter FSM states
//   *_IDX       - requester / sprite indices
package team_08_pkg;

    typedef enum logic [1:0] {IDLE, RUN, WIN, OVER} state_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_START, ARB_WAIT, ARB_DONE} arb_state_t;

    localparam int DINO_IDX   = 0;
    localparam int CACTUS_IDX = 1;
    localparam int SCORE_IDX  = 2;

endpackage

// File: rtl/team_08_arb_pick.sv
// team_08_arb_pick: combinational one-hot picker searching from (ptr+1) mod N.
//   mask   - eligible requesters
//   ptr    - last served index; search starts just after it (ptr=N-1 gives fixed priority)
//   onehot - one-hot winner, all-zero when mask is empty
//   idx    - binary index of the winner
module team_08_arb_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx
);

    localparam int W = $clog2(N);

    logic [W-1:0] c;

    // Walk the search order backwards so the earliest eligible candidate is
    // the last one written and therefore wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        c      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            c = W'((int'(ptr) + 1 + i) % N);
            if (mask[c]) begin
                onehot    = '0;
                onehot[c] = 1'b1;
                idx       = c;
            end
        end
    end

endmodule

// File: rtl/team_08_draw_arbiter.sv
// team_08_draw_arbiter: shares the pixel-drawing engine among sprite requesters.
//   clk, nRst   - clock, asynchronous active-low reset
//   state       - game state; outside RUN only the dino request is eligible
//   req         - level requests, held until the matching drawDone
//   engineBusy  - engine busy, sampled only while idle
//   engineDone  - engine completion pulse, honoured only while waiting
//   gnt/drawSel - registered one-hot grant and its binary index
//   drawStart   - one-cycle engine start pulse
//   drawDone    - one-cycle completion pulse to the granted requester
//   timeoutErr  - sticky watchdog-timeout flag
// Define TEAM_08_DRAW_RR_EN for round-robin arbitration; otherwise fixed priority.
module team_08_draw_arbiter
    import team_08_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       nRst,
    input  state_t                     state,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       engineBusy,
    input  logic                       engineDone,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] drawSel,
    output logic                       drawStart,
    output logic [NUM_REQ-1:0]         drawDone,
    output logic                       timeoutErr
);

    localparam int SW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t         cur, nxt;
    logic [NUM_REQ-1:0] elig, pick_oh;
    logic [SW-1:0]      pick_idx, ptr;
    logic [WW-1:0]      wdog;
    logic               timeout_hit, grant_now;

    assign elig        = (state == RUN) ? req : NUM_REQ'(req[DINO_IDX]) << DINO_IDX;
    assign timeout_hit = (wdog == WW'(TIMEOUT_CYCLES - 1));
    assign grant_now   = (cur == ARB_IDLE) && (nxt == ARB_START);

    team_08_arb_pick #(.N(NUM_REQ)) u_pick (
        .mask   (elig),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

`ifdef TEAM_08_DRAW_RR_EN
    always_ff @(posedge clk or negedge nRst)
        if (!nRst)
            ptr <= SW'(NUM_REQ - 1);
        else if (grant_now)
            ptr <= pick_idx;
`else
    assign ptr = SW'(NUM_REQ - 1);
`endif

    always_comb begin
        nxt       = cur;
        drawStart = 1'b0;
        drawDone  = '0;
        unique case (cur)
            ARB_IDLE:  nxt = (|elig && !engineBusy) ? ARB_START : ARB_IDLE;
            ARB_START: begin
                drawStart = 1'b1;
                nxt       = ARB_WAIT;
            end
            ARB_WAIT:  nxt = (engineDone || timeout_hit) ? ARB_DONE : ARB_WAIT;
            ARB_DONE:  begin
                drawDone = gnt;
                nxt      = ARB_IDLE;
            end
            default:   nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst)
        if (!nRst) begin
            cur        <= ARB_IDLE;
            gnt        <= '0;
            drawSel    <= '0;
            wdog       <= '0;
            timeoutErr <= 1'b0;
        end else begin
            cur <= nxt;
            if (grant_now) begin
                gnt     <= pick_oh;
                drawSel <= pick_idx;
            end
            if (cur == ARB_DONE)
                gnt <= '0;
            // Saturating watchdog so a stuck count can never wrap back to zero.
            if (cur == ARB_START)
                wdog <= '0;
            else if (cur == ARB_WAIT && wdog != '1)
                wdog <= wdog + WW'(1);
            if (cur == ARB_WAIT && !engineDone && timeout_hit)
                timeoutErr <= 1'b1;
        end

endmodule

// File: tb/tb_team_08_draw_arbiter.sv
// tb_team_08_draw_arbiter: vector table, corner sequences and a random run against a transaction model.
module tb_team_08_draw_arbiter;
    import team_08_pkg::*;

    localparam int N = 3;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         nRst;
    state_t       st;
    logic [N-1:0] req;
    logic         busy, edone;
    logic [N-1:0] gnt, ddone;
    logic [1:0]   sel;
    logic         dstart, terr;

    int checks = 0;
    int failures = 0;

    team_08_draw_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .state      (st),
        .req        (req),
        .engineBusy (busy),
        .engineDone (edone),
        .gnt        (gnt),
        .drawSel    (sel),
        .drawStart  (dstart),
        .drawDone   (ddone),
        .timeoutErr (terr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        state_t       st;
        logic         busy;
        logic         edone;
        logic [N-1:0] eg;
        logic         es;
        logic [N-1:0] ed;
    } vec_t;

    vec_t vecs[25];

    // Transaction model: who owns the engine, how many cycles since its grant,
    // and whether the completion pulse is being delivered this cycle.
    int owner, age, last;
    bit fin, mterr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mpick(input logic [N-1:0] elig, input int from);
        int r;
        r = -1;
`ifdef TEAM_08_DRAW_RR_EN
        for (int k = N; k >= 1; k--)
            if (elig[(from + k) % N]) r = (from + k) % N;
`else
        for (int k = N - 1; k >= 0; k--)
            if (elig[k]) r = k;
`endif
        return r;
    endfunction

    task automatic model_reset();
        owner = -1;
        age   = 0;
        last  = N - 1;
        fin   = 1'b0;
        mterr = 1'b0;
    endtask

    task automatic model_step();
        logic [N-1:0] elig;
        elig = (st == RUN) ? req : (req & 3'b001);
        if (owner < 0) begin
            if (elig != 0 && !busy) begin
                owner = mpick(elig, last);
                age   = 0;
                fin   = 1'b0;
`ifdef TEAM_08_DRAW_RR_EN
                last  = owner;
`endif
            end
        end else if (fin)
            owner = -1;
        else if (age == 0)
            age = 1;
        else if (edone)
            fin = 1'b1;
        else if (age == T) begin
            fin   = 1'b1;
            mterr = 1'b1;
        end else
            age++;
    endtask

    initial begin
        int n;
        logic [N-1:0] eg, ed;

        vecs[0]  = '{3'b001, RUN,  1'b0, 1'b0, 3'b001, 1'b1, 3'b000};
        vecs[1]  = '{3'b001, RUN,  1'b0, 1'b0, 3'b001, 1'b0, 3'b000};
        vecs[2]  = '{3'b001, RUN,  1'b0, 1'b1, 3'b001, 1'b0, 3'b001};
        vecs[3]  = '{3'b000, RUN,  1'b0, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[4]  = '{3'b110, RUN,  1'b0, 1'b0, 3'b010, 1'b1, 3'b000};
        vecs[5]  = '{3'b110, RUN,  1'b0, 1'b0, 3'b010, 1'b0, 3'b000};
        vecs[6]  = '{3'b110, RUN,  1'b0, 1'b1, 3'b010, 1'b0, 3'b010};
        vecs[7]  = '{3'b100, RUN,  1'b0, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[8]  = '{3'b100, RUN,  1'b0, 1'b0, 3'b100, 1'b1, 3'b000};
        vecs[9]  = '{3'b100, RUN,  1'b0, 1'b0, 3'b100, 1'b0, 3'b000};
        vecs[10] = '{3'b100, RUN,  1'b0, 1'b1, 3'b100, 1'b0, 3'b100};
        vecs[11] = '{3'b000, RUN,  1'b0, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[12] = '{3'b110, OVER, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[13] = '{3'b011, OVER, 1'b0, 1'b0, 3'b001, 1'b1, 3'b000};
        vecs[14] = '{3'b011, OVER, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000};
        vecs[15] = '{3'b011, OVER, 1'b0, 1'b1, 3'b001, 1'b0, 3'b001};
        vecs[16] = '{3'b010, OVER, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[17] = '{3'b010, OVER, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[18] = '{3'b001, RUN,  1'b1, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[19] = '{3'b001, RUN,  1'b1, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[20] = '{3'b001, RUN,  1'b0, 1'b0, 3'b001, 1'b1, 3'b000};
        vecs[21] = '{3'b001, RUN,  1'b0, 1'b1, 3'b001, 1'b0, 3'b000};
        vecs[22] = '{3'b001, RUN,  1'b0, 1'b0, 3'b001, 1'b0, 3'b000};
        vecs[23] = '{3'b001, RUN,  1'b0, 1'b1, 3'b001, 1'b0, 3'b001};
        vecs[24] = '{3'b000, RUN,  1'b0, 1'b0, 3'b000, 1'b0, 3'b000};

        nRst  = 1'b0;
        st    = RUN;
        req   = '0;
        busy  = 1'b0;
        edone = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_sel", sel, 0);
        chk("rst_start", dstart, 0);
        chk("rst_done", ddone, 0);
        chk("rst_terr", terr, 0);
        nRst = 1'b1;
        tick();

        foreach (vecs[i]) begin
            req   = vecs[i].req;
            st    = vecs[i].st;
            busy  = vecs[i].busy;
            edone = vecs[i].edone;
            tick();
            chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].eg);
            chk($sformatf("vec%0d_start", i), dstart, vecs[i].es);
            chk($sformatf("vec%0d_done", i), ddone, vecs[i].ed);
            chk($sformatf("vec%0d_terr", i), terr, 0);
        end
        chk("vec_sel0", sel, 0);

        // Watchdog: engine never completes.
        req = 3'b001;
        n = 0;
        tick();
        while (!dstart && n < 10) begin
            tick();
            n++;
        end
        chk("to_start", dstart, 1);
        n = 0;
        while (ddone == 0 && n < 40) begin
            tick();
            n++;
        end
        chk("to_latency", n, 17);
        chk("to_done", ddone, 3'b001);
        chk("to_terr", terr, 1);
        req = '0;
        tick();
        chk("to_terr_sticky", terr, 1);
        req = 3'b001;
        tick();
        chk("post_to_start", dstart, 1);
        tick();
        edone = 1'b1;
        tick();
        edone = 1'b0;
        chk("post_to_done", ddone, 3'b001);
        req = '0;
        tick();
        chk("post_to_idle", gnt, 0);
        chk("post_to_terr", terr, 1);

        // Asynchronous reset while waiting on the engine.
        req = 3'b001;
        repeat (3) tick();
        chk("ar_pre_gnt", gnt, 3'b001);
        #2 nRst = 1'b0;
        #1;
        chk("ar_gnt", gnt, 0);
        chk("ar_start", dstart, 0);
        chk("ar_done", ddone, 0);
        chk("ar_terr", terr, 0);
        tick();
        nRst = 1'b1;
        tick();
        chk("ar_regrant", gnt, 3'b001);
        chk("ar_restart", dstart, 1);
        tick();
        edone = 1'b1;
        tick();
        edone = 1'b0;
        chk("ar_finish", ddone, 3'b001);
        req = '0;

        // Randomized run against the transaction model.
        nRst = 1'b0;
        st   = RUN;
        tick();
        nRst = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) st = state_t'($urandom_range(0, 3));
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(0, 99) == 0) req[i] = 1'b0;
            busy  = ($urandom_range(0, 3) == 0);
            edone = ($urandom_range(0, 5) == 0);
            model_step();
            tick();
            eg = (owner >= 0) ? 3'(1 << owner) : 3'b000;
            ed = (owner >= 0 && fin) ? eg : 3'b000;
            chk("rnd_gnt", gnt, eg);
            chk("rnd_start", dstart, (owner >= 0 && age == 0));
            chk("rnd_done", ddone, ed);
            chk("rnd_terr", terr, mterr);
            if (owner >= 0) chk("rnd_sel", sel, owner);
            req = req & ~ed;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
